// File: rtl/fifo_rd_packer.sv
// -----------------------------------------------------------------------------
// fifo_rd_packer
//
// Read-side consumer of an asynchronous FIFO, entirely in the read clock
// domain. Pops DWIDTH-bit words, packs PACK consecutive words into one wide
// word (first-popped word in lane 0 / LSBs) and presents it on a valid/ready
// stream. A flush request emits a partially filled word with its lane count.
//
// Parameters
//   DWIDTH      width of one FIFO word
//   PACK        FIFO words per output word (2..16)
//   CNTW        width of the lane count
//
// Ports
//   rclk        read-domain clock, all logic on the rising edge
//   reset       asynchronous active-high reset
//   fifo_empty  FIFO empty flag
//   fifo_pop    FIFO pop request (combinational)
//   fifo_rdata  FIFO read data, valid the cycle after an accepted pop
//   flush       single-cycle request to emit the partial word
//   flush_busy  flush in progress
//   out_valid   output word valid
//   out_ready   downstream accepts
//   out_data    packed word, unused lanes are zero
//   out_cnt     number of valid lanes (1..PACK)
//   out_par     per-lane even parity (only with RDPACK_PARITY_EN)
//
// Build option
//   RDPACK_PARITY_EN  when defined, adds out_par, registered with out_data.
// -----------------------------------------------------------------------------
module fifo_rd_packer #(
    parameter int DWIDTH = 8,
    parameter int PACK   = 4,
    parameter int CNTW   = $clog2(PACK) + 1
) (
    input  logic                   rclk,
    input  logic                   reset,
    input  logic                   fifo_empty,
    output logic                   fifo_pop,
    input  logic [DWIDTH-1:0]      fifo_rdata,
    input  logic                   flush,
    output logic                   flush_busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PACK*DWIDTH-1:0] out_data,
    output logic [CNTW-1:0]        out_cnt
`ifdef RDPACK_PARITY_EN
    ,
    output logic [PACK-1:0]        out_par
`endif
);

    // FILL: accumulating, HOLD: full and waiting for the output stage,
    // FLUSH: flush pending (new pops blocked).
    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_nxt;

    logic [DWIDTH-1:0]        acc [PACK];
    logic [CNTW-1:0]          acc_cnt;
    logic                     p1;          // a pop was accepted last cycle

    logic                     acc_ready;
    logic                     xfer;
    logic [CNTW-1:0]          eff_cnt;
    logic [CNTW-1:0]          fill_cnt;
    logic [PACK*DWIDTH-1:0]   packed_data;
`ifdef RDPACK_PARITY_EN
    logic [PACK-1:0]          packed_par;
`endif

    // -------------------------------------------------------------------------
    // Datapath control
    // -------------------------------------------------------------------------
    assign xfer     = acc_ready && (!out_valid || out_ready);
    // A transfer empties the accumulator this cycle, so a landing word and
    // the pop decision already see the freed lanes.
    assign eff_cnt  = xfer ? '0 : acc_cnt;
    // Lanes occupied once the in-flight word lands; never exceeds PACK
    // because a pop is only issued while this stays below PACK.
    assign fill_cnt = eff_cnt + CNTW'(p1);
    assign fifo_pop = !reset && !fifo_empty && !flush_busy
                      && (fill_cnt < CNTW'(PACK));

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FILL, ST_HOLD: begin
                if (flush) begin
                    state_nxt = ST_FLUSH;
                end else if (fill_cnt == CNTW'(PACK)) begin
                    state_nxt = ST_HOLD;
                end else begin
                    state_nxt = ST_FILL;
                end
            end
            // Leaving FLUSH needs the in-flight word landed: either the
            // (partial or full) word is moving out, or there was nothing.
            ST_FLUSH: begin
                if (!p1 && (xfer || acc_cnt == '0)) begin
                    state_nxt = ST_FILL;
                end
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        acc_ready  = 1'b0;
        flush_busy = 1'b0;
        case (state)
            ST_HOLD:  acc_ready = 1'b1;
            // A full accumulator implies no word in flight, so this also
            // covers a flush that arrives while the accumulator is full.
            ST_FLUSH: begin
                acc_ready  = !p1 && (acc_cnt != '0);
                flush_busy = 1'b1;
            end
            default:  acc_ready = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Accumulator lanes
    // -------------------------------------------------------------------------
    // NOTE: lane storage carries no reset; acc_cnt alone says which lanes
    // hold live data and unused lanes are masked on transfer.
    always_ff @(posedge rclk) begin
        for (int i = 0; i < PACK; i++) begin
            if (p1 && eff_cnt == CNTW'(i)) begin
                acc[i] <= fifo_rdata;
            end
        end
    end

    // Word presented to the output stage, unused lanes forced to zero.
    always_comb begin
        packed_data = '0;
`ifdef RDPACK_PARITY_EN
        packed_par  = '0;
`endif
        for (int i = 0; i < PACK; i++) begin
            if (CNTW'(i) < acc_cnt) begin
                packed_data[i*DWIDTH +: DWIDTH] = acc[i];
`ifdef RDPACK_PARITY_EN
                packed_par[i]                   = ^acc[i];
`endif
            end
        end
    end

    // -------------------------------------------------------------------------
    // Counters and output stage
    // -------------------------------------------------------------------------
    always_ff @(posedge rclk or posedge reset) begin
        if (reset) begin
            acc_cnt   <= '0;
            p1        <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
`ifdef RDPACK_PARITY_EN
            out_par   <= '0;
`endif
        end else begin
            acc_cnt <= fill_cnt;
            p1      <= fifo_pop;
            // Load has priority over accept: back-to-back words keep
            // out_valid high; otherwise the stage holds until accepted.
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= packed_data;
                out_cnt   <= acc_cnt;
`ifdef RDPACK_PARITY_EN
                out_par   <= packed_par;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer of the asynchronous FIFO, living entirely in the read clock domain. It pops DWIDTH-bit words from the FIFO read port, packs PACK consecutive words into one wide word, and presents it on a valid/ready output stream. A flush request emits a partially filled word with a lane count.

## Interface
- DWIDTH, 8, width of one FIFO word
- PACK, 4, FIFO words per output word (2..16)
- CNTW, $clog2(PACK)+1, width of lane count
- rclk  input  1  read-domain clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- fifo_empty  input  1  FIFO empty flag
- fifo_pop  output  1  FIFO pop request
- fifo_rdata  input  DWIDTH  FIFO read data, valid the cycle after an accepted pop
- flush  input  1  single-cycle request to emit the partial word
- flush_busy  output  1  flush in progress
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts
- out_data  output  PACK*DWIDTH  packed word; first-popped word in lane 0 (LSBs)
- out_cnt  output  CNTW  number of valid lanes (1..PACK)

## Operation
- Registers:
  - accumulator `acc` with lanes 0..PACK-1
  - `acc_cnt` (0..PACK)
  - in-flight bit `p1` = fifo_pop of the previous cycle
  - output stage (out_valid, out_data, out_cnt)
  - `flush_pend`
- xfer (acc → output stage) occurs when the accumulator is ready and (!out_valid or out_ready).
  - Ready means acc_cnt==PACK, or flush_pend && !p1 && acc_cnt>0.
- On xfer:
  - out_data = acc, with unused lanes forced to 0.
  - out_cnt = acc_cnt.
  - acc_cnt is cleared.
- eff_cnt = xfer ? 0 : acc_cnt.
- fifo_pop = !reset && !fifo_empty && !flush_pend && (eff_cnt + p1 < PACK). This is combinational from registered state and fifo_empty.
- When p1 is set, fifo_rdata is written into lane eff_cnt and acc_cnt = eff_cnt+1. Overflow cannot occur by construction.
- Output handshake:
  - out_valid stays high until out_ready.
  - out_data and out_cnt are stable while out_valid && !out_ready.
  - Accept and xfer in the same cycle loads the new word back-to-back.
- Flush:
  - flush sets flush_pend, which stops new pops.
  - The in-flight word still lands.
  - If acc_cnt>0 after p1 clears, the partial word is transferred.
  - flush_pend clears on that xfer, or immediately once !p1 && acc_cnt==0 (no output).
  - flush while flush_pend is ignored.
  - flush on the same cycle acc_cnt reaches PACK: the full word goes out normally, then the flush completes with no extra word.
  - flush_busy = flush_pend.
- FSM states, derived from acc_cnt and flush_pend:
  - FILL (acc_cnt<PACK, !flush_pend) → HOLD when acc_cnt==PACK.
  - HOLD (full, waiting for the output stage) → FILL on xfer.
  - FLUSH (flush_pend) → FILL on completion.
- Reset (asynchronous, any time, including mid-packing or mid-handshake):
  - out_valid=0, out_data=0, out_cnt=0, flush_busy=0.
  - acc_cnt=0, p1=0, flush_pend=0.
  - fifo_pop=0 while reset is high.
  - Words in flight are discarded.

## Timing
- Pop accepted in cycle N → data written into acc at the end of cycle N+1.
- Streaming, PACK=4, FIFO never empty, out_ready=1:
  - pops in cycles 0–3;
  - cycle 4 stalled (acc_cnt=3, p1=1);
  - xfer in cycle 5, with a pop also in cycle 5;
  - out_valid high from cycle 6.
- Steady-state throughput: PACK words per PACK+1 cycles.
- Output stalled (out_ready=0): at most PACK words are absorbed into acc after the output stage fills, then fifo_pop stays 0.
- Flush latency: flush in cycle N with p1=0 and acc_cnt>0 → out_valid in cycle N+2 if the output stage is free.

## Configuration
- RDPACK_PARITY_EN:
  - Defined: adds output port out_par [PACK-1:0], the even parity of each lane, registered with out_data. Unused lanes have parity 0.
  - Undefined: the port and its logic are absent. Behaviour is otherwise identical.

## Test plan
- Reset: assert reset mid-packing (acc_cnt=2, p1=1) → immediately out_valid=0, out_cnt=0, fifo_pop=0. After release, the next 4 words form a clean new word.
- Streaming: PACK=4, DWIDTH=8, FIFO holds 0x01..0x08, out_ready=1 → out_data 0x04030201 (cnt 4), then 0x08070605 (cnt 4). First out_valid at cycle 6 after the first pop.
- Backpressure: out_ready=0 with 12 words available → exactly 8 pops occur, then fifo_pop=0. out_data stays 0x04030201. Releasing out_ready drains both words in order with no loss.
- Flush partial: pop 0xA1, 0xB2, then flush → out_data 0x0000B2A1, out_cnt=2. flush_busy drops on the xfer.
- Flush edge cases: flush with acc_cnt=0 → no output and flush_busy low after 1 cycle. Flush coinciding with the 4th landing → exactly one full word with cnt=4.
- With RDPACK_PARITY_EN: lanes 0x01, 0x03, 0x07, 0xFF → out_par=4'b0101.
